// File: rtl/ir_stream_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : ir_stream_loader_if                                  |
// | Description : Control, write and IR-side signal bundle for the     |
// |               instruction stream loader.                           |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
interface ir_stream_loader_if #(
  parameter int WIDTH = 32,
  parameter int PTR_W = 3
);
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             clear;
  logic             start;
  logic             loop_mode;
  logic             abort;
  logic             cu_ready;
  logic [WIDTH-1:0] IR_In;
  logic             IR_Enable;
  logic             busy;
  logic             done;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             overflow;

  // Driver side: bench, host or control unit
  modport master (
    output wr_en, wr_data, clear, start, loop_mode, abort, cu_ready,
    input  IR_In, IR_Enable, busy, done, count, full, empty, overflow
  );

  // Loader side
  modport slave (
    input  wr_en, wr_data, clear, start, loop_mode, abort, cu_ready,
    output IR_In, IR_Enable, busy, done, count, full, empty, overflow
  );
endinterface
`default_nettype wire

// File: rtl/ir_stream_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : ir_stream_loader                                     |
// | Description : Buffers up to DEPTH instruction words and injects    |
// |               them into the IR as single-cycle IR_Enable pulses,   |
// |               with a minimum idle gap, control-unit handshake and  |
// |               optional looping.                                    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module ir_stream_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int GAP   = 2
) (
  input  logic               Clk,
  input  logic               RESET,
  ir_stream_loader_if.slave  bus
);

  localparam int GAP_W = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rp_q, rp_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               loop_q, loop_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [WIDTH-1:0]   ir_in_q, ir_in_d;
  logic               ir_en_q, ir_en_d;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               mem_we;
  logic [PTR_W-1:0]   wp;
  logic               is_full;
  logic               is_empty;
  logic               last_entry;

  // The write pointer always equals the entry count (both clear together and
  // advance together), and a write is only accepted while count < DEPTH, so
  // the low bits of count address the next free slot.
  assign wp         = count_q[PTR_W-1:0];
  assign is_full    = (count_q == (PTR_W+1)'(DEPTH));
  assign is_empty   = (count_q == '0);
  assign last_entry = ({1'b0, rp_q} == (count_q - (PTR_W+1)'(1)));

  // Next-state, buffer bookkeeping and IR strobe generation
  always_comb begin
    state_d    = state_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    loop_d     = loop_q;
    gap_d      = gap_q;
    ir_in_d    = ir_in_q;
    ir_en_d    = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !is_empty && !bus.abort) begin
          // Any write in this cycle is dropped: start wins.
          rp_d    = '0;
          loop_d  = bus.loop_mode;
          ir_in_d = mem_q[0];
          ir_en_d = 1'b1;
          gap_d   = GAP_W'(GAP);
          state_d = LOAD;
        end else if (bus.clear) begin
          count_d    = '0;
          overflow_d = 1'b0;
        end else if (bus.wr_en) begin
          if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            mem_we  = 1'b1;
            count_d = count_q + (PTR_W+1)'(1);
          end
        end
      end

      LOAD: begin
        // The gap count starts in LOAD so that GAP idle cycles follow the pulse.
        gap_d   = gap_q - GAP_W'(1);
        state_d = WAIT;
      end

      WAIT: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (bus.cu_ready) begin
          if (last_entry && !loop_q) begin
            state_d = DONE;
          end else begin
            rp_d    = last_entry ? '0 : rp_q + PTR_W'(1);
            ir_in_d = mem_q[rp_d];
            ir_en_d = 1'b1;
            gap_d   = GAP_W'(GAP);
            state_d = LOAD;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort returns to IDLE from anywhere; the IR word is left as it was.
    if (bus.abort) begin
      state_d = IDLE;
      ir_en_d = 1'b0;
      ir_in_d = ir_in_q;
    end
  end

  // Control and output registers with asynchronous reset
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      loop_q     <= 1'b0;
      gap_q      <= '0;
      ir_in_q    <= '0;
      ir_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      loop_q     <= loop_d;
      gap_q      <= gap_d;
      ir_in_q    <= ir_in_d;
      ir_en_q    <= ir_en_d;
    end
  end

  // Instruction storage; contents survive reset and clear
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[wp] <= bus.wr_data;
    end
  end

  assign bus.IR_In     = ir_in_q;
  assign bus.IR_Enable = ir_en_q;
  assign bus.busy      = (state_q == LOAD) || (state_q == WAIT);
  assign bus.done      = (state_q == DONE);
  assign bus.count     = count_q;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.overflow  = overflow_q;

endmodule
`default_nettype wire
